alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter W, default 10: operand, register and result width; legal range 4..32.
REQ-002 Parameter MUL_EN, default 1: 1 enables the multi-cycle multiply op; 0 makes FN=1100 behave as an undefined code.
REQ-003 Port CLKb  in  1: sole clock; all state updates on the falling edge.
REQ-004 Port RST  in  1: synchronous, active-high reset, sampled on the falling edge of CLKb.
REQ-005 Port OP  in  W: shared operand bus.
REQ-006 Port FN  in  4: function select, sampled with Gout.
REQ-007 Port Ain  in  1: load OP into operand register A.
REQ-008 Port Gin  in  1: load OP into operand register B.
REQ-009 Port Gout  in  1: start the operation selected by FN.
REQ-010 Port Q  out  W: registered result.
REQ-011 Port FLAGS  out  4: registered {Z,N,C,V} for the last completed op.
REQ-012 Port BUSY  out  1: high while a multiply is in progress.
REQ-013 Port DONE  out  1: one-cycle pulse when Q/FLAGS update.

Function
REQ-014 Ain/Gin SHALL load A/B at the falling edge when BUSY=0; both may load the same edge; ignored while BUSY=1.
REQ-015 Gout with a single-cycle FN SHALL compute from the A/B values held before that edge (same-edge loads not visible); Q, FLAGS and DONE=1 SHALL update at that edge.
REQ-016 FN codes SHALL be: 0010 A+B, 0011 A-B, 0100 -B, 0101 ~B, 0110 A&B, 0111 A|B, 1000 A^B, 1001 A<<B, 1010 A>>B (logical), 1011 A>>>B (arithmetic, A signed), 1100 multiply.
REQ-017 Results SHALL be truncated to W bits; shift amount is the full unsigned B.
REQ-018 For B>=W: lsl and lsr SHALL give 0; asr SHALL give all bits equal to A[W-1].
REQ-019 Z SHALL be (Q==0); N SHALL be Q[W-1].
REQ-020 C SHALL be: add carry-out; sub/inv NOT borrow (A>=B unsigned; inv uses A=0); shifts the last bit shifted out (0 if B=0 or B>W); mul 1 if the upper W bits of the 2W product are nonzero; logic ops 0.
REQ-021 V SHALL be two's-complement overflow for add, sub and inv; 0 for all other ops.
REQ-022 Undefined FN with Gout SHALL give Q=0, FLAGS=1000, DONE pulse.
REQ-023 Multiply SHALL be unsigned shift-add, one partial step per cycle: Gout at edge k sets BUSY=1; edges k+1..k+W iterate; edge k+W writes Q = low W bits of A*B and FLAGS, clears BUSY, and pulses DONE.
REQ-024 Operands SHALL be snapshotted at edge k; Gout, Ain and Gin SHALL be ignored while BUSY=1.
REQ-025 Q and FLAGS SHALL hold their value between operations; DONE SHALL be 0 on every edge without a completion.

Reset
REQ-026 RST=1 at a falling edge SHALL set A=B=Q=0, FLAGS=0000, BUSY=0, DONE=0, and abort any multiply; RST has priority over Ain/Gin/Gout.
REQ-027 The first edge with RST=0 SHALL accept Ain/Gin/Gout normally.

Verification (W=10)
REQ-028 A=1023, B=1, FN=0010 -> Q=0, FLAGS Z=1 C=1 N=0 V=0, DONE pulse; A=511, B=1 add -> Q=512, N=1 V=1.
REQ-029 A=5, B=7, FN=0011 -> Q=1022, N=1 C=0 V=0; A=0, B=512, FN=0100 -> Q=512, V=1.
REQ-030 A=0x200, B=3, FN=1011 -> Q=0x3C0; B=12, FN=1001 -> Q=0; A=0x200, B=12, FN=1011 -> Q=0x3FF.
REQ-031 A=25, B=30, FN=1100 -> BUSY high 10 cycles, Ain pulse during BUSY ignored, then Q=750, C=0, DONE one cycle; A=100, B=20 -> Q=976, C=1.
REQ-032 RST asserted 4 cycles into a multiply -> next edge BUSY=0, Q=0, FLAGS=0, no DONE pulse; new op accepted on the first edge after RST deasserts.
REQ-033 Ain and Gout on the same edge with FN=0010 -> result uses the old A; the next add uses the new A.

Source files
------------

// File: rtl/alu_seq_if.sv
// Operand/result bus of the sequential ALU: operand loads, op start, and the
// registered result with its status and handshake.
interface alu_seq_if #(
  parameter int W = 10
);
  logic [W-1:0] OP;
  logic [3:0]   FN;
  logic         Ain;
  logic         Gin;
  logic         Gout;
  logic [W-1:0] Q;
  logic [3:0]   FLAGS;
  logic         BUSY;
  logic         DONE;

  modport master (
    output OP, FN, Ain, Gin, Gout,
    input  Q, FLAGS, BUSY, DONE
  );

  modport slave (
    input  OP, FN, Ain, Gin, Gout,
    output Q, FLAGS, BUSY, DONE
  );
endinterface

// File: rtl/alu_seq.sv
// Two-operand ALU on a shared bus: single-cycle arithmetic/logic/shift ops and
// an optional W-cycle unsigned shift-add multiply. All state moves on the CLKb falling edge.
module alu_seq #(
  parameter int W      = 10,
  parameter bit MUL_EN = 1'b1
) (
  input  logic      CLKb,
  input  logic      RST,
  alu_seq_if.slave  bus
);

  localparam int            CW       = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [W-1:0]  W_VAL    = W[W-1:0];

  typedef enum logic [3:0] {
    FN_ADD = 4'b0010,
    FN_SUB = 4'b0011,
    FN_NEG = 4'b0100,
    FN_NOT = 4'b0101,
    FN_AND = 4'b0110,
    FN_OR  = 4'b0111,
    FN_XOR = 4'b1000,
    FN_LSL = 4'b1001,
    FN_LSR = 4'b1010,
    FN_ASR = 4'b1011,
    FN_MUL = 4'b1100
  } fn_e;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    q_q, q_d;
  logic [3:0]      flags_q, flags_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [2*W-1:0]  acc_q, acc_d, mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Single-cycle datapath; shifts carry one guard bit so the last bit
  // shifted out falls naturally into the extra position.
  logic [W:0]        add_ext, lsl_ext, lsr_ext;
  logic signed [W:0] asr_ext;
  logic [W-1:0]      sub_res, neg_res;
  logic [W-1:0]      alu_q;
  logic              alu_c, alu_v;
  logic [3:0]        alu_flags;
  logic [2*W-1:0]    acc_step;

  assign add_ext = {1'b0, a_q} + {1'b0, b_q};
  assign sub_res = a_q - b_q;
  assign neg_res = '0 - b_q;
  assign lsl_ext = {1'b0, a_q} << b_q;
  assign lsr_ext = {a_q, 1'b0} >> b_q;
  assign asr_ext = $signed({a_q, 1'b0}) >>> b_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    alu_q = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (bus.FN)
      FN_ADD: begin
        alu_q = add_ext[W-1:0];
        alu_c = add_ext[W];
        alu_v = (a_q[W-1] == b_q[W-1]) && (add_ext[W-1] != a_q[W-1]);
      end
      FN_SUB: begin
        alu_q = sub_res;
        alu_c = (a_q >= b_q);
        alu_v = (a_q[W-1] != b_q[W-1]) && (sub_res[W-1] != a_q[W-1]);
      end
      FN_NEG: begin
        alu_q = neg_res;
        alu_c = (b_q == '0);
        alu_v = b_q[W-1] && neg_res[W-1];
      end
      FN_NOT: alu_q = ~b_q;
      FN_AND: alu_q = a_q & b_q;
      FN_OR:  alu_q = a_q | b_q;
      FN_XOR: alu_q = a_q ^ b_q;
      FN_LSL: begin
        alu_q = lsl_ext[W-1:0];
        alu_c = lsl_ext[W];
      end
      FN_LSR: begin
        alu_q = lsr_ext[W:1];
        alu_c = lsr_ext[0];
      end
      FN_ASR: begin
        alu_q = asr_ext[W:1];
        alu_c = (b_q > W_VAL) ? 1'b0 : asr_ext[0];
      end
      default: ;  // undefined codes (and multiply, handled separately) give Q=0
    endcase
  end

  assign alu_flags = {alu_q == '0, alu_q[W-1], alu_c, alu_v};
  assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    q_d      = q_q;
    flags_d  = flags_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.Ain) a_d = bus.OP;
        if (bus.Gin) b_d = bus.OP;
        if (bus.Gout) begin
          if (MUL_EN && (bus.FN == FN_MUL)) begin
            // Operands come from the registers as held before this edge.
            state_d  = S_MUL;
            busy_d   = 1'b1;
            acc_d    = '0;
            mcand_d  = {{W{1'b0}}, a_q};
            mplier_d = b_q;
            cnt_d    = '0;
          end else begin
            q_d     = alu_q;
            flags_d = alu_flags;
            done_d  = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          q_d     = acc_step[W-1:0];
          flags_d = {acc_step[W-1:0] == '0, acc_step[W-1], |acc_step[2*W-1:W], 1'b0};
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(negedge CLKb) begin
    if (RST) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      q_q      <= '0;
      flags_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      q_q      <= q_d;
      flags_q  <= flags_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.Q     = q_q;
  assign bus.FLAGS = flags_q;
  assign bus.BUSY  = busy_q;
  assign bus.DONE  = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (W=10): expected results are queued when an op
// is started and compared whenever DONE is seen.
module tb_alu_seq;

  localparam int W = 10;

  typedef struct {
    string        tag;
    logic [W-1:0] q;
    logic [3:0]   f;
  } exp_t;

  logic clk_b = 1'b1;
  logic rst   = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  logic [W-1:0] model_a, model_b;

  alu_seq_if #(.W(W)) bus ();

  alu_seq #(.W(W), .MUL_EN(1'b1)) dut (
    .CLKb (clk_b),
    .RST  (rst),
    .bus  (bus)
  );

  always #5 clk_b = ~clk_b;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, need done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change after a rising edge, the DUT samples on the falling edge,
  // and outputs are observed on the following rising edge.
  task automatic tick();
    @(negedge clk_b);
    @(posedge clk_b);
  endtask

  // Scoreboard: every DONE pulse retires the oldest expected result.
  always @(posedge clk_b) begin
    if (bus.DONE === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_q"}, bus.Q, e.q);
        check({e.tag, "_flags"}, bus.FLAGS, e.f);
      end
    end
  end

  // Reference model written from the op definitions using wide integers and
  // bit-by-bit shifting loops.
  function automatic logic [W+3:0] model(input logic [3:0] fn, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    int unsigned ua, ub, us;
    int          sa, sb_v, sr;
    longint unsigned p;
    logic [W-1:0] q;
    logic c, v;
    ua = a; ub = b;
    sa = $signed(a); sb_v = $signed(b);
    q = '0; c = 1'b0; v = 1'b0;
    case (fn)
      4'b0010: begin
        us = ua + ub; sr = sa + sb_v;
        q = us[W-1:0]; c = (us > 1023); v = (sr > 511) || (sr < -512);
      end
      4'b0011: begin
        sr = sa - sb_v; q = sr[W-1:0]; c = (ua >= ub); v = (sr > 511) || (sr < -512);
      end
      4'b0100: begin
        sr = -sb_v; q = sr[W-1:0]; c = (ub == 0); v = (sr > 511) || (sr < -512);
      end
      4'b0101: q = ~b;
      4'b0110: q = a & b;
      4'b0111: q = a | b;
      4'b1000: q = a ^ b;
      4'b1001: begin
        q = a;
        for (int i = 0; i < int'(ub); i++) begin c = q[W-1]; q = q << 1; end
      end
      4'b1010: begin
        q = a;
        for (int i = 0; i < int'(ub); i++) begin c = q[0]; q = q >> 1; end
      end
      4'b1011: begin
        q = a;
        for (int i = 0; i < int'(ub); i++) begin c = q[0]; q = {q[W-1], q[W-1:1]}; end
        if (ub > W) c = 1'b0;
      end
      4'b1100: begin
        p = longint'(ua) * longint'(ub);
        q = p[W-1:0]; c = ((p >> W) != 0);
      end
      default: ;
    endcase
    return {q, q == '0, q[W-1], c, v};
  endfunction

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.OP = a; bus.Ain = 1'b1; tick(); bus.Ain = 1'b0;
    bus.OP = b; bus.Gin = 1'b1; tick(); bus.Gin = 1'b0;
    model_a = a; model_b = b;
  endtask

  task automatic run_op(input string tag, input logic [3:0] fn, input logic [W-1:0] eq,
                        input logic [3:0] ef, input bit poke);
    int c;
    sb.push_back('{tag, eq, ef});
    bus.FN = fn; bus.Gout = 1'b1; tick(); bus.Gout = 1'b0;
    if (fn == 4'b1100) begin
      c = 0;
      for (int i = 0; i < 3 * W && bus.DONE !== 1'b1; i++) begin
        if (bus.BUSY === 1'b1) c++;
        bus.OP  = 10'd1;
        bus.Ain = poke && (c == 3);
        tick();
      end
      bus.Ain = 1'b0;
      check({tag, "_done"}, bus.DONE, 1);
      check({tag, "_busy_cycles"}, c, W);
      check({tag, "_busy_end"}, bus.BUSY, 0);
    end else begin
      check({tag, "_done"}, bus.DONE, 1);
    end
    tick();
    check({tag, "_done_low"}, bus.DONE, 0);
  endtask

  task automatic run_model(input string tag, input logic [3:0] fn);
    logic [W+3:0] r;
    r = model(fn, model_a, model_b);
    run_op(tag, fn, r[W+3:4], r[3:0], 1'b0);
  endtask

  initial begin
    bus.OP = '0; bus.FN = '0; bus.Ain = 1'b0; bus.Gin = 1'b0; bus.Gout = 1'b0;
    model_a = '0; model_b = '0;
    @(posedge clk_b);
    tick(); tick();
    check("rst_q", bus.Q, 0);
    check("rst_flags", bus.FLAGS, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_done", bus.DONE, 0);
    rst = 1'b0;

    load(10'd1023, 10'd1);  run_op("add_wrap", 4'b0010, 10'd0,   4'b1010, 1'b0);
    load(10'd511,  10'd1);  run_op("add_ovf",  4'b0010, 10'd512, 4'b0101, 1'b0);
    load(10'd5,    10'd7);  run_op("sub_neg",  4'b0011, 10'd1022, 4'b0100, 1'b0);
    load(10'd0,    10'd512); run_op("neg_ovf", 4'b0100, 10'd512, 4'b0101, 1'b0);
    load(10'h200,  10'd3);  run_op("asr_3",    4'b1011, 10'h3C0, 4'b0100, 1'b0);
    load(10'h200,  10'd12); run_op("lsl_big",  4'b1001, 10'd0,   4'b1000, 1'b0);
    run_op("asr_big", 4'b1011, 10'h3FF, 4'b0100, 1'b0);
    run_op("undef",   4'b0000, 10'd0,   4'b1000, 1'b0);
    load(10'h155,  10'd10); run_model("lsl_w", 4'b1001);
    run_model("lsr_w", 4'b1010);

    // Multiply with an Ain pulse during BUSY that must be ignored.
    load(10'd25, 10'd30);   run_op("mul_750", 4'b1100, 10'd750, 4'b0100, 1'b1);
    run_op("add_after_mul", 4'b0010, 10'd55, 4'b0000, 1'b0);
    load(10'd100, 10'd20);  run_op("mul_976", 4'b1100, 10'd976, 4'b0110, 1'b0);

    // Same-edge load and add: result uses the old A, the next add the new one.
    load(10'd5, 10'd3);
    sb.push_back('{"same_edge", 10'd8, 4'b0000});
    bus.OP = 10'd20; bus.Ain = 1'b1; bus.FN = 4'b0010; bus.Gout = 1'b1;
    tick();
    bus.Ain = 1'b0; bus.Gout = 1'b0;
    check("same_edge_done", bus.DONE, 1);
    run_op("new_a_add", 4'b0010, 10'd23, 4'b0000, 1'b0);

    // Reset four cycles into a multiply aborts it with no completion.
    load(10'd25, 10'd30);
    bus.FN = 4'b1100; bus.Gout = 1'b1; tick(); bus.Gout = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; tick();
    check("abort_busy", bus.BUSY, 0);
    check("abort_q", bus.Q, 0);
    check("abort_flags", bus.FLAGS, 0);
    check("abort_done", bus.DONE, 0);
    tick();
    check("abort_no_done", bus.DONE, 0);
    model_a = '0; model_b = '0;
    rst = 1'b0;
    sb.push_back('{"post_rst_not", 10'h3FF, 4'b0100});
    bus.OP = 10'd7; bus.Ain = 1'b1; bus.FN = 4'b0101; bus.Gout = 1'b1;
    tick();
    bus.Ain = 1'b0; bus.Gout = 1'b0;
    check("post_rst_done", bus.DONE, 1);
    model_a = 10'd7;
    run_op("post_rst_add", 4'b0010, 10'd7, 4'b0000, 1'b0);

    // Randomised ops against the reference model.
    for (int k = 0; k < 16; k++) begin
      logic [W-1:0] ra, rb;
      logic [3:0]   rf;
      ra = W'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 12)) : W'($urandom);
      rf = 4'($urandom_range(0, 15));
      load(ra, rb);
      run_model($sformatf("rnd%0d_fn%0h", k, rf), rf);
    end

    tick();
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
